// File: rtl/pipe_buf_stage_pkg.sv
// Shared widths and helpers for the elastic pipeline stage buffer.
// Default payload is {pc, instruction} for the IF->ID boundary.
package pipe_buf_stage_pkg;

  localparam int BUS_WIDTH  = 32;
  localparam int DATA_WIDTH = 32;
  localparam int PAYLOAD_W_DEF = BUS_WIDTH + DATA_WIDTH;

  // Pointer width; a single-entry buffer still needs a 1-bit pointer.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pipe_buf_ptr.sv
// Wrap-around buffer pointer with increment enable and synchronous clear.
// Wraps from DEPTH-1 to 0, so DEPTH need not be a power of two.
module pipe_buf_ptr #(
  parameter int DEPTH = 2,
  parameter int PTR_W = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [PTR_W-1:0] ptr
);

  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == LAST) ? '0 : ptr + PTR_W'(1);
    end
  end

endmodule

// File: rtl/pipe_buf_stage.sv
// Pipeline stage register with a DEPTH-entry elastic buffer.
// DEPTH=1, REG_ALLOW_IN=0 behaves as a single stage register.
module pipe_buf_stage
  import pipe_buf_stage_pkg::*;
#(
  parameter int PAYLOAD_W    = PAYLOAD_W_DEF,
  parameter int DEPTH        = 2,
  parameter int REG_ALLOW_IN = 0,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = ptr_w(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 hold,
  input  logic                 valid_pre,
  input  logic                 ready_go_pre,
  input  logic [PAYLOAD_W-1:0] data_in,
  output logic                 allow_in_out,
  output logic                 valid_out,
  output logic                 ready_go_out,
  output logic [PAYLOAD_W-1:0] data_out,
  input  logic                 allow_in_next,
  output logic [CNT_W-1:0]     count,
  output logic                 full,
  output logic                 empty
);

  logic [PAYLOAD_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W-1:0]     wr_ptr;
  logic                 push;
  logic                 pop;

  assign empty        = (count == '0);
  assign full         = (count == CNT_W'(DEPTH));
  assign valid_out    = ~empty;
  assign ready_go_out = ~hold;
  assign data_out     = mem[rd_ptr];

  // Registered variant drops the allow_in_next -> allow_in_out path.
  generate
    if (REG_ALLOW_IN != 0) begin : g_reg_ai
      assign allow_in_out = ~full;
    end else begin : g_comb_ai
      assign allow_in_out = ~full | pop;
    end
  endgenerate

  assign push = valid_pre & ready_go_pre & ~flush & allow_in_out;
  assign pop  = valid_out & ready_go_out & allow_in_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else if (push & ~pop) begin
      count <= count + CNT_W'(1);
    end else if (pop & ~push) begin
      count <= count - CNT_W'(1);
    end
  end

  // When full, wr_ptr equals rd_ptr: a push with pop reuses the freed slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= data_in;
    end
  end

  pipe_buf_ptr #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .inc   (pop),
    .ptr   (rd_ptr)
  );

  pipe_buf_ptr #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .inc   (push),
    .ptr   (wr_ptr)
  );

endmodule

// File: tb/tb_pipe_buf_stage.sv
// Scoreboard bench for pipe_buf_stage across four configurations.
// Shared stimulus; one selected instance is modelled and checked.
module tb_pipe_buf_stage;

  localparam int W = 16;

  logic         clk;
  logic         rst_n;
  logic         flush;
  logic         hold;
  logic         valid_pre;
  logic         ready_go_pre;
  logic [W-1:0] data_in;
  logic         allow_in_next;

  logic         ai  [4];
  logic         vo  [4];
  logic         rgo [4];
  logic [W-1:0] dout[4];
  logic         fu  [4];
  logic         em  [4];
  logic [1:0]   cnt0;
  logic [1:0]   cnt1;
  logic [1:0]   cnt2;
  logic         cnt3;

  int dep [4] = '{2, 2, 3, 1};
  int rai [4] = '{0, 1, 0, 0};

  int           sel;
  int           mcnt;
  int           popped;
  int           pushed;
  logic [W-1:0] q[$];
  int           n_chk;
  int           n_fail;

  pipe_buf_stage #(.PAYLOAD_W(W), .DEPTH(2), .REG_ALLOW_IN(0)) u0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .hold(hold),
    .valid_pre(valid_pre), .ready_go_pre(ready_go_pre), .data_in(data_in),
    .allow_in_out(ai[0]), .valid_out(vo[0]), .ready_go_out(rgo[0]),
    .data_out(dout[0]), .allow_in_next(allow_in_next),
    .count(cnt0), .full(fu[0]), .empty(em[0]));

  pipe_buf_stage #(.PAYLOAD_W(W), .DEPTH(2), .REG_ALLOW_IN(1)) u1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .hold(hold),
    .valid_pre(valid_pre), .ready_go_pre(ready_go_pre), .data_in(data_in),
    .allow_in_out(ai[1]), .valid_out(vo[1]), .ready_go_out(rgo[1]),
    .data_out(dout[1]), .allow_in_next(allow_in_next),
    .count(cnt1), .full(fu[1]), .empty(em[1]));

  pipe_buf_stage #(.PAYLOAD_W(W), .DEPTH(3), .REG_ALLOW_IN(0)) u2 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .hold(hold),
    .valid_pre(valid_pre), .ready_go_pre(ready_go_pre), .data_in(data_in),
    .allow_in_out(ai[2]), .valid_out(vo[2]), .ready_go_out(rgo[2]),
    .data_out(dout[2]), .allow_in_next(allow_in_next),
    .count(cnt2), .full(fu[2]), .empty(em[2]));

  pipe_buf_stage #(.PAYLOAD_W(W), .DEPTH(1), .REG_ALLOW_IN(0)) u3 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .hold(hold),
    .valid_pre(valid_pre), .ready_go_pre(ready_go_pre), .data_in(data_in),
    .allow_in_out(ai[3]), .valid_out(vo[3]), .ready_go_out(rgo[3]),
    .data_out(dout[3]), .allow_in_next(allow_in_next),
    .count(cnt3), .full(fu[3]), .empty(em[3]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  function automatic int get_cnt(input int s);
    case (s)
      0:       return int'(cnt0);
      1:       return int'(cnt1);
      2:       return int'(cnt2);
      default: return int'(cnt3);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cfg %0d, t=%0t)",
               tag, got, exp, sel, $time);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    flush = 1'b0; hold = 1'b0;
    valid_pre = 1'b0; ready_go_pre = 1'b0;
    data_in = '0; allow_in_next = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mcnt = 0; popped = 0; pushed = 0;
    q.delete();
  endtask

  // One cycle: drive after negedge, check against model, advance model.
  task automatic step(input logic v, input logic [W-1:0] d, input logic h,
                      input logic f, input logic an);
    logic e_pop, e_full, e_ai, e_push;
    valid_pre = v; ready_go_pre = v; data_in = d;
    hold = h; flush = f; allow_in_next = an;
    #1;
    e_pop  = (mcnt != 0) && !h && an;
    e_full = (mcnt == dep[sel]);
    e_ai   = (rai[sel] != 0) ? !e_full : (!e_full || e_pop);
    e_push = v && !f && e_ai;
    chk("count", get_cnt(sel), mcnt);
    chk("cnt_bound", get_cnt(sel) <= dep[sel], 1);
    chk("valid_out", vo[sel], mcnt != 0);
    chk("allow_in", ai[sel], e_ai);
    chk("ready_go", rgo[sel], !h);
    chk("full", fu[sel], e_full);
    chk("empty", em[sel], mcnt == 0);
    if (mcnt != 0) chk("data_out", dout[sel], q[0]);
    if (e_pop) begin
      void'(q.pop_front());
      popped++;
    end
    if (f) begin
      q.delete();
    end else if (e_push) begin
      q.push_back(d);
      pushed++;
    end
    mcnt = q.size();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    sel = 0;
    do_reset();

    // Async reset mid-cycle with two entries.
    step(1'b1, 16'h000A, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h000B, 1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_valid", vo[0], 0);
    chk("rst_count", get_cnt(0), 0);
    chk("rst_data", dout[0], 0);
    chk("rst_allow_in", ai[0], 1);
    chk("rst_empty", em[0], 1);
    chk("rst_full", fu[0], 0);
    do_reset();

    // Fill then drain, DEPTH=2.
    step(1'b1, 16'h000A, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h000B, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h00FF, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("drain_pops", popped, 2);

    // Full pass-through with combinational allow_in.
    do_reset();
    step(1'b1, 16'h000A, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h000B, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h000C, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("pass_pushed", pushed, 3);
    chk("pass_popped", popped, 3);

    // Same with registered allow_in: C is refused.
    sel = 1;
    do_reset();
    step(1'b1, 16'h000A, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h000B, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h000C, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("reg_pushed", pushed, 2);
    chk("reg_popped", popped, 2);

    // Hold for three cycles, pushes continue until full.
    sel = 0;
    do_reset();
    step(1'b1, 16'h0011, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h0022, 1'b1, 1'b0, 1'b1);
    step(1'b1, 16'h0033, 1'b1, 1'b0, 1'b1);
    step(1'b1, 16'h0044, 1'b1, 1'b0, 1'b1);
    chk("hold_no_pop", popped, 0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("hold_resume", popped, 2);

    // Flush with a same-cycle push, also while held.
    do_reset();
    step(1'b1, 16'h0055, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h0066, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h0077, 1'b1, 1'b1, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 16'h0088, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("flush_popped", popped, 1);

    // DEPTH=3 wrap with random back-pressure.
    sel = 2;
    do_reset();
    for (int i = 0; i < 60 && popped < 10; i++) begin
      logic [W-1:0] nd;
      nd = W'(16'h0100 + pushed);
      step(pushed < 10, nd, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
    end
    chk("wrap_pushed", pushed, 10);
    chk("wrap_popped", popped, 10);

    // DEPTH=1 back-to-back stream.
    sel = 3;
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, W'(16'h0200 + i), 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("stream_pushed", pushed, 8);
    chk("stream_popped", popped, 8);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
